// File: rtl/bin2bcd_serial.sv
// Serial binary-to-BCD converter (shift-and-add-3, one input bit per clock).
// A start/done handshake frames each conversion; ovf flags results that need more than D digits.
module bin2bcd_serial #(
  parameter int unsigned W = 8,
  parameter int unsigned D = 3
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [W-1:0]   bin,
  output logic           busy,
  output logic           done,
  output logic [4*D-1:0] bcd,
  output logic           ovf
);

  localparam int unsigned BW = 4 * D;
  localparam int unsigned CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FINISH
  } state_t;

  state_t          state;
  logic [W-1:0]    shreg;
  logic [BW-1:0]   scratch;
  logic [BW-1:0]   adj;
  logic [BW-1:0]   scratch_nxt;
  logic            carry_out;
  logic            sticky;
  logic [CW-1:0]   count;

  // Per-digit add-3 correction; digits are independent, no inter-digit carry.
  always_comb begin
    adj = '0;
    for (int i = 0; i < int'(D); i++) begin
      if (scratch[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
      else                            adj[4*i +: 4] = scratch[4*i +: 4];
    end
  end

  // The bit leaving the top digit carries weight 10^D and is lost from bcd.
  assign carry_out   = adj[BW-1];
  assign scratch_nxt = {adj[BW-2:0], shreg[W-1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      shreg   <= '0;
      scratch <= '0;
      sticky  <= 1'b0;
      count   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd     <= '0;
      ovf     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, FINISH: begin
          if (start) begin
            shreg   <= bin;
            scratch <= '0;
            sticky  <= 1'b0;
            count   <= CW'(W);
            busy    <= 1'b1;
            state   <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          scratch <= scratch_nxt;
          shreg   <= shreg << 1;
          sticky  <= sticky | carry_out;
          count   <= count - CW'(1);
          // Last iteration publishes the result on the same edge.
          if (count == CW'(1)) begin
            bcd   <= scratch_nxt;
            ovf   <= sticky | carry_out;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= FINISH;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
